// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus host arbiter.
//   arb_state_e  : arbiter FSM state (IDLE / BUSY)
//   TimeoutCntW  : width of the response timeout counter
package bus_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned TimeoutCntW = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per host
//   ptr   : host index where the upward (wrapping) search starts
//   gnt   : one-hot grant of the first requester found
//   idx   : binary index of that requester
//   valid : at least one request is pending
module rr_arbiter #(
   parameter int unsigned NrHosts = 2,
   localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1
) (
   input  logic [NrHosts-1:0] req,
   input  logic [IdxW-1:0]    ptr,
   output logic [NrHosts-1:0] gnt,
   output logic [IdxW-1:0]    idx,
   output logic               valid
);

   logic [IdxW-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         cand = IdxW'((32'(ptr) + i) % NrHosts);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_host_arbiter.sv
// Multi-host to single-device bus arbiter with one outstanding transaction.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   host_req_i/host_gnt_o : per-host request and same-cycle grant
//   host_addr_i/we/be/wdata : per-host request payload
//   host_rvalid_o/rdata/err : per-host response (only the owner's lane is driven)
//   dev_req_o ... dev_wdata_o : shared downstream request (zero unless granting)
//   dev_rvalid_i/rdata/err    : shared downstream response
// A transaction that sees no device response for TimeoutCycles BUSY cycles
// is closed with an error response to its owner.
module bus_host_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned NrHosts       = 2,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddressWidth  = 32,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NrHosts-1:0]                    host_req_i,
   output logic [NrHosts-1:0]                    host_gnt_o,
   input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
   input  logic [NrHosts-1:0]                    host_we_i,
   input  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i,
   input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
   output logic [NrHosts-1:0]                    host_rvalid_o,
   output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
   output logic [NrHosts-1:0]                    host_err_o,
   output logic                                  dev_req_o,
   output logic [AddressWidth-1:0]               dev_addr_o,
   output logic                                  dev_we_o,
   output logic [DataWidth/8-1:0]                dev_be_o,
   output logic [DataWidth-1:0]                  dev_wdata_o,
   input  logic                                  dev_rvalid_i,
   input  logic [DataWidth-1:0]                  dev_rdata_i,
   input  logic                                  dev_err_i
);

   localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

   arb_state_e             state;
   logic [IdxW-1:0]        owner;
   logic [IdxW-1:0]        rr_ptr;
   logic [TimeoutCntW-1:0] cnt;

   logic [NrHosts-1:0]     win_gnt;
   logic [IdxW-1:0]        win_idx;
   logic                   win_vld;
   logic                   grant;
   logic                   busy;
   logic                   timeout;

   function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] idx);
      if (idx == IdxW'(NrHosts - 1)) return '0;
      return idx + IdxW'(1);
   endfunction

   rr_arbiter #(.NrHosts(NrHosts)) u_rr (
      .req   (host_req_i),
      .ptr   (rr_ptr),
      .gnt   (win_gnt),
      .idx   (win_idx),
      .valid (win_vld)
   );

   // Outputs are gated with rst_i so they read zero while reset is held,
   // even though grant and response paths are combinational.
   assign grant   = !rst_i && (state == IDLE) && win_vld;
   assign busy    = !rst_i && (state == BUSY);
   // Counter is 0 in the first BUSY cycle, so the last allowed wait cycle
   // (TimeoutCycles after the grant) is the one where it holds TimeoutCycles-1.
   assign timeout = (cnt == TimeoutCntW'(TimeoutCycles - 1));

   always_comb begin
      host_gnt_o    = '0;
      dev_req_o     = 1'b0;
      dev_addr_o    = '0;
      dev_we_o      = 1'b0;
      dev_be_o      = '0;
      dev_wdata_o   = '0;
      host_rvalid_o = '0;
      host_rdata_o  = '0;
      host_err_o    = '0;
      if (grant) begin
         host_gnt_o  = win_gnt;
         dev_req_o   = 1'b1;
         dev_addr_o  = host_addr_i[win_idx];
         dev_we_o    = host_we_i[win_idx];
         dev_be_o    = host_be_i[win_idx];
         dev_wdata_o = host_wdata_i[win_idx];
      end
      if (busy) begin
         // A real device response wins over a coincident timeout.
         if (dev_rvalid_i) begin
            host_rvalid_o[owner] = 1'b1;
            host_rdata_o[owner]  = dev_rdata_i;
            host_err_o[owner]    = dev_err_i;
         end else if (timeout) begin
            host_rvalid_o[owner] = 1'b1;
            host_err_o[owner]    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state  <= BUSY;
                  owner  <= win_idx;
                  rr_ptr <= next_ptr(win_idx);
                  cnt    <= '0;
               end
            end
            BUSY: begin
               if (dev_rvalid_i || timeout) state <= IDLE;
               else                         cnt   <= cnt + TimeoutCntW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_host_arbiter.sv
module tb_bus_host_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 16;

   logic                    clk;
   logic                    rst;
   logic [N-1:0]            host_req;
   logic [N-1:0]            host_gnt;
   logic [N-1:0][AW-1:0]    host_addr;
   logic [N-1:0]            host_we;
   logic [N-1:0][DW/8-1:0]  host_be;
   logic [N-1:0][DW-1:0]    host_wdata;
   logic [N-1:0]            host_rvalid;
   logic [N-1:0][DW-1:0]    host_rdata;
   logic [N-1:0]            host_err;
   logic                    dev_req;
   logic [AW-1:0]           dev_addr;
   logic                    dev_we;
   logic [DW/8-1:0]         dev_be;
   logic [DW-1:0]           dev_wdata;
   logic                    dev_rvalid;
   logic [DW-1:0]           dev_rdata;
   logic                    dev_err;

   bus_host_arbiter #(
      .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .host_req_i(host_req), .host_gnt_o(host_gnt),
      .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be),
      .host_wdata_i(host_wdata),
      .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
      .dev_req_o(dev_req), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
      .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
      .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          host;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc;
   int   total;
   int   passed;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // Advance to the next falling edge; inputs are driven here and outputs
   // sampled #1 later, well away from the rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Response monitor: any host_rvalid must match the scoreboard head,
   // and an entry whose cycle has come without a response is a failure.
   task automatic mon();
      exp_t             e;
      logic [N-1:0]     ev;
      logic [N-1:0][DW-1:0] ed;
      logic [N-1:0]     ee;
      if (host_rvalid != '0) begin
         if (sbq.size() == 0) begin
            chk("unexpected_rvalid", 96'(host_rvalid), 96'(0));
         end else begin
            e  = sbq.pop_front();
            ev = '0; ed = '0; ee = '0;
            ev[e.host] = 1'b1;
            ed[e.host] = e.data;
            ee[e.host] = e.err;
            chk("rsp_rvalid", 96'(host_rvalid), 96'(ev));
            chk("rsp_rdata",  96'(host_rdata),  96'(ed));
            chk("rsp_err",    96'(host_err),    96'(ee));
            chk("rsp_cycle",  96'(cyc),         96'(e.cyc));
         end
      end else begin
         chk("idle_rsp_lanes", 96'({host_rdata, host_err}), 96'(0));
         if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e  = sbq.pop_front();
            ev = '0;
            ev[e.host] = 1'b1;
            chk("missing_rvalid", 96'(host_rvalid), 96'(ev));
         end
      end
   endtask

   task automatic push(input int host, input logic [31:0] data, input logic err, input int at);
      exp_t e;
      e.host = host; e.data = data; e.err = err; e.cyc = at;
      sbq.push_back(e);
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int          g;
   logic [31:0] d;
   logic        er;

   initial begin
      cyc        = 0;
      total      = 0;
      passed     = 0;
      rst        = 1'b1;
      host_req   = '0;
      host_addr  = '0;
      host_we    = '0;
      host_be    = '0;
      host_wdata = '0;
      dev_rvalid = 1'b0;
      dev_rdata  = '0;
      dev_err    = 1'b0;

      // Reset: outputs zero even with requests and a device response present
      tick();
      host_req   = 2'b11;
      dev_rvalid = 1'b1;
      dev_rdata  = 32'hFFFF_FFFF;
      #1;
      chk("rst_gnt",     96'(host_gnt),    96'(0));
      chk("rst_dev_req", 96'({dev_req, dev_addr, dev_we, dev_be}), 96'(0));
      chk("rst_rvalid",  96'({host_rvalid, host_err}), 96'(0));
      tick();
      rst        = 1'b0;
      host_req   = '0;
      dev_rvalid = 1'b0;
      dev_rdata  = '0;

      // Single read from host 0, device answers one cycle later
      tick();
      host_req[0]  = 1'b1;
      host_addr[0] = 32'h0010_0000;
      host_we[0]   = 1'b0;
      host_be[0]   = 4'hF;
      #1;
      chk("rd_gnt",      96'(host_gnt),   96'(2'b01));
      chk("rd_dev_req",  96'(dev_req),    96'(1));
      chk("rd_dev_addr", 96'(dev_addr),   96'(32'h0010_0000));
      chk("rd_dev_we_be", 96'({dev_we, dev_be}), 96'({1'b0, 4'hF}));
      mon();
      tick();
      host_req   = '0;
      dev_rvalid = 1'b1;
      dev_rdata  = 32'hDEAD_BEEF;
      dev_err    = 1'b0;
      push(0, 32'hDEAD_BEEF, 1'b0, cyc);
      #1;
      chk("busy_no_gnt", 96'(host_gnt), 96'(0));
      mon();

      // Late device response in IDLE is dropped; payload zero when not granting
      tick();
      dev_rdata = 32'h1234_5678;
      #1;
      chk("late_rvalid",   96'({host_rvalid, host_err}), 96'(0));
      chk("idle_dev_bus",  96'({dev_req, dev_addr, dev_we, dev_be}), 96'(0));
      chk("idle_dev_wdat", 96'(dev_wdata), 96'(0));
      mon();
      tick();
      dev_rvalid = 1'b0;

      // Round robin: both hosts request continuously, device answers at once
      do_reset();
      host_addr[0]  = 32'h0000_0100; host_we[0] = 1'b0; host_be[0] = 4'hF;
      host_wdata[0] = 32'h0;
      host_addr[1]  = 32'h0000_0200; host_we[1] = 1'b1; host_be[1] = 4'h3;
      host_wdata[1] = 32'h1234_5678;
      for (int i = 0; i < 8; i++) begin
         tick();
         host_req   = 2'b11;
         dev_rvalid = 1'b1;
         d          = 32'hA000_0000 + 32'(i);
         er         = (i % 4) == 3;
         dev_rdata  = d;
         dev_err    = er;
         if (i % 2 == 1) push((i / 2) % 2, d, er, cyc);
         #1;
         if (i % 2 == 0) begin
            if ((i / 2) % 2 == 0) begin
               chk("rr_gnt0",  96'(host_gnt), 96'(2'b01));
               chk("rr_pay0",  96'({dev_addr, dev_we, dev_be, dev_wdata}),
                   96'({32'h100, 1'b0, 4'hF, 32'h0}));
            end else begin
               chk("rr_gnt1",  96'(host_gnt), 96'(2'b10));
               chk("rr_pay1",  96'({dev_addr, dev_we, dev_be, dev_wdata}),
                   96'({32'h200, 1'b1, 4'h3, 32'h1234_5678}));
            end
         end else begin
            chk("rr_resp_no_gnt", 96'({host_gnt, dev_req}), 96'(0));
         end
         mon();
      end
      tick();
      host_req   = '0;
      dev_rvalid = 1'b0;
      dev_err    = 1'b0;
      #1;
      mon();

      // Timeout: host 1 alone, device silent
      do_reset();
      tick();
      host_req  = 2'b10;
      dev_rdata = 32'hCAFE_F00D;
      #1;
      chk("to_gnt", 96'(host_gnt), 96'(2'b10));
      g = cyc;
      push(1, 32'h0, 1'b1, g + int'(TO));
      mon();
      for (int i = 1; i <= int'(TO) + 3; i++) begin
         tick();
         host_req = '0;
         #1;
         mon();
      end
      chk("to_sb_empty", 96'(sbq.size()), 96'(0));

      // Device response on the timeout cycle takes precedence
      tick();
      host_req = 2'b01;
      #1;
      chk("pre_gnt", 96'(host_gnt), 96'(2'b01));
      g = cyc;
      mon();
      for (int i = 1; i <= int'(TO) + 2; i++) begin
         tick();
         host_req   = '0;
         dev_rvalid = (cyc == g + int'(TO));
         dev_rdata  = 32'h5;
         dev_err    = 1'b0;
         if (dev_rvalid) push(0, 32'h5, 1'b0, cyc);
         #1;
         mon();
      end
      chk("pre_sb_empty", 96'(sbq.size()), 96'(0));
      dev_rvalid = 1'b0;

      // Reset while BUSY abandons the transaction and clears rr_ptr
      tick();
      host_req = 2'b01;
      #1;
      chk("mid_gnt", 96'(host_gnt), 96'(2'b01));
      tick();
      host_req = '0;
      rst      = 1'b1;
      #1;
      chk("mid_rst_out", 96'({host_gnt, host_rvalid, dev_req}), 96'(0));
      tick();
      rst = 1'b0;
      tick();
      dev_rvalid = 1'b1;
      dev_rdata  = 32'h7777_7777;
      #1;
      chk("mid_no_rvalid", 96'({host_rvalid, host_err}), 96'(0));
      mon();
      tick();
      dev_rvalid = 1'b0;
      host_req   = 2'b11;
      #1;
      chk("mid_ptr_zero", 96'(host_gnt), 96'(2'b01));
      tick();
      host_req = '0;
      #1;
      mon();
      chk("final_sb_empty", 96'(sbq.size()), 96'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bus_host_arbiter.md
BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

Interface
REQ-001 Parameter NrHosts, default 2, SHALL set the number of requesting hosts (2..8).
REQ-002 Parameter DataWidth, default 32, SHALL set the data bus width.
REQ-003 Parameter AddressWidth, default 32, SHALL set the address bus width.
REQ-004 Parameter TimeoutCycles, default 16, SHALL set the maximum wait in BUSY before a forced error response (1..255).
REQ-005 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 Port host_req_i, input, [NrHosts] x 1: per-host request.
REQ-008 Port host_gnt_o, output, [NrHosts] x 1: per-host grant.
REQ-009 Port host_addr_i / host_we_i / host_be_i / host_wdata_i, input, [NrHosts] x AddressWidth / 1 / DataWidth/8 / DataWidth: per-host request payload.
REQ-010 Port host_rvalid_o, output, [NrHosts] x 1: per-host response valid.
REQ-011 Port host_rdata_o, output, [NrHosts] x DataWidth: response data.
REQ-012 Port host_err_o, output, [NrHosts] x 1: response error.
REQ-013 Port dev_req_o / dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o, output, 1 / AddressWidth / 1 / DataWidth/8 / DataWidth: shared downstream request.
REQ-014 Port dev_rvalid_i / dev_rdata_i / dev_err_i, input, 1 / DataWidth / 1: shared downstream response.

Function
REQ-015 Block SHALL implement FSM with states IDLE and BUSY; at most one transaction outstanding.
REQ-016 In IDLE with any host_req_i set, winner SHALL be the first requesting host searching upward (wrapping) from rr_ptr.
REQ-017 Grant SHALL be combinational, same cycle: host_gnt_o[winner]=1, dev_req_o=1, dev_* payload = winner's payload; FSM -> BUSY, owner <= winner, rr_ptr <= (winner+1) mod NrHosts.
REQ-018 At most one host_gnt_o bit SHALL be set in any cycle; no grant in BUSY or with no request.
REQ-019 When not granting, dev_req_o SHALL be 0 and dev_addr_o/dev_we_o/dev_be_o/dev_wdata_o SHALL be 0.
REQ-020 In BUSY, dev_rvalid_i=1 SHALL drive host_rvalid_o[owner]=1, host_rdata_o[owner]=dev_rdata_i, host_err_o[owner]=dev_err_i in the same cycle; FSM -> IDLE.
REQ-021 Non-owner host_rvalid_o/host_rdata_o/host_err_o SHALL be 0.
REQ-022 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without dev_rvalid_i.
REQ-023 When counter reaches TimeoutCycles, block SHALL drive host_rvalid_o[owner]=1, host_err_o[owner]=1, host_rdata_o[owner]=0; FSM -> IDLE.
REQ-024 dev_rvalid_i and timeout in the same cycle: device response SHALL take precedence.
REQ-025 dev_rvalid_i while in IDLE (late response) SHALL be ignored, not forwarded.
REQ-026 Next grant SHALL not occur in the cycle the response returns; minimum spacing grant-to-grant is 2 cycles.

Reset
REQ-027 On rst_i: state IDLE, rr_ptr 0, owner 0, counter 0; all outputs 0.
REQ-028 Reset mid-transaction SHALL abandon it; no host_rvalid_o issued for it after reset release.

Structure
REQ-029 Shared package bus_arb_pkg SHALL hold the FSM state enum and the timeout counter width constant (8 bits).
REQ-030 Round-robin pick SHALL be a combinational sub-module rr_arbiter (req vector, pointer in; one-hot grant, index out).

Verification
REQ-031 Host0 only, read 0x100000, device rvalid 1 cycle later with 0xDEADBEEF -> gnt[0] cycle 0, rvalid[0] cycle 1 with 0xDEADBEEF, err 0.
REQ-032 Both hosts requesting continuously after reset -> grants alternate 0,1,0,1 every 2 cycles.
REQ-033 Host1 request, device never responds, TimeoutCycles=16 -> rvalid[1]=1, err[1]=1, rdata 0 exactly 16 cycles after grant.
REQ-034 Response arriving on the timeout cycle with dev_err_i=0, data 0x5 -> rvalid with err 0, data 0x5.
REQ-035 rst_i asserted in BUSY, device rvalid pulsed after release -> no host_rvalid_o, state IDLE, rr_ptr 0.
